// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The optional halt-on-ecall feature is enabled by defining FETCH_HALT_EN.
package fetch_pkg;

  localparam int ADDR_W = 7;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] ECALL_WORD = 32'h0000_0073;
  localparam logic [ADDR_W-1:0] PC_STEP    = 7'd4;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = 7'h7C;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ROM, redirect and decode-handshake bundle of the fetch unit.
// master = fetch unit side, slave = ROM/execute/decode side.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output rom_en, rom_addr, inst_valid, inst_data, inst_pc,
    input  rom_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  rom_en, rom_addr, inst_valid, inst_data, inst_pc,
    output rom_data, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {data, pc}; the head slot is itself the registered output,
// the second slot shifts into it on a pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  input  logic   flush,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  entry_t     tail_r;
  logic [1:0] count_r;
  logic       do_pop_s;

  assign do_pop_s = pop && (count_r != 2'd0);
  assign full     = (count_r == 2'd2);
  assign empty    = (count_r == 2'd0);

  // Occupancy and slot update; push with a full queue only arrives together with a pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= 2'd0;
      head    <= '0;
      tail_r  <= '0;
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case ({push, do_pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head <= push_entry;
          end else begin
            tail_r <= push_entry;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head    <= tail_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head <= push_entry;
          end else begin
            head   <= tail_r;
            tail_r <= push_entry;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, one ROM read per cycle, 2-entry queue to decode, redirect flush.
// Define FETCH_HALT_EN to stop fetching after an ecall word has been pushed.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 7'd0
)
(
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  fetch_state_e      state_r;
  fetch_state_e      next_state_s;
  logic [ADDR_W-1:0] pc_r;
  logic              fetch_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  entry_t            head_s;
  entry_t            push_entry_s;

  assign pop_s        = !empty_s && bus.inst_ready;
  assign push_entry_s = '{data: bus.rom_data, pc: pc_r};

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fetch_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (bus.redirect_valid),
    .full       (full_s),
    .empty      (empty_s),
    .head       (head_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state: redirect always resumes; optionally an ecall fetch halts
  always_comb begin
    next_state_s = state_r;
    if (bus.redirect_valid) begin
      next_state_s = RUN;
`ifdef FETCH_HALT_EN
    end else if (fetch_s && (bus.rom_data == ECALL_WORD)) begin
      next_state_s = HALT;
`endif
    end else begin
      next_state_s = state_r;
    end
  end

  // Fetch decision; a pop frees a slot in the same cycle
  always_comb begin
    fetch_s = 1'b0;
    if (rst_n && (state_r == RUN) && !bus.redirect_valid && (!full_s || pop_s)) begin
      fetch_s = 1'b1;
    end else begin
      fetch_s = 1'b0;
    end
  end

  // Program counter, wraps naturally at 2^ADDR_W
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r <= word_align(RESET_PC);
    end else if (bus.redirect_valid) begin
      pc_r <= word_align(bus.redirect_pc);
    end else if (fetch_s) begin
      pc_r <= pc_r + PC_STEP;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign bus.rom_en     = fetch_s;
  assign bus.rom_addr   = pc_r;
  assign bus.inst_valid = !empty_s;
  assign bus.inst_data  = head_s.data;
  assign bus.inst_pc    = head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;

  fetch_unit_if bus_if();

  fetch_unit #(.RESET_PC(7'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [0:31];
  assign bus_if.rom_data = rom[bus_if.rom_addr[6:2]];

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit rv, input logic [6:0] rpc, input bit rdy);
    rst_n                 = r;
    bus_if.redirect_valid = rv;
    bus_if.redirect_pc    = rpc;
    bus_if.inst_ready     = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: list of queued {data, pc}, a PC counter and a halt flag
  typedef struct {
    logic [31:0] data;
    int          pc;
  } ref_t;

  ref_t mq[$];
  int   mpc   = 0;
  bit   mhalt = 1'b0;

  task automatic model_cycle(input bit r, input bit rv, input int rpc, input bit rdy);
    bit   en;
    ref_t e;
    drive(r, rv, rpc[6:0], rdy);
    en = r && !mhalt && !rv && (mq.size() < 2 || (mq.size() > 0 && rdy));
    check("rnd.rom_en", {31'd0, bus_if.rom_en}, {31'd0, en});
    check("rnd.rom_addr", {25'd0, bus_if.rom_addr}, mpc);
    check("rnd.inst_valid", {31'd0, bus_if.inst_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
    if (mq.size() > 0) begin
      check("rnd.inst_pc", {25'd0, bus_if.inst_pc}, mq[0].pc);
      check("rnd.inst_data", bus_if.inst_data, mq[0].data);
    end
    tick();
    if (!r) begin
      mq.delete();
      mpc   = 0;
      mhalt = 1'b0;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (rv) begin
        mq.delete();
        mpc   = rpc & 'h7C;
        mhalt = 1'b0;
      end else if (en) begin
        e.data = rom[mpc / 4];
        e.pc   = mpc;
        mq.push_back(e);
`ifdef FETCH_HALT_EN
        if (e.data == 32'h0000_0073) mhalt = 1'b1;
`endif
        mpc = (mpc + 4) % 128;
      end
    end
  endtask

  typedef struct {
    bit         rv;
    logic [6:0] rpc;
    bit         rdy;
    bit         en;
    logic [6:0] addr;
    bit         vld;
    logic [6:0] ipc;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int exp_pc;
    bit exp_en;
    bit exp_vld;
    int exp_addr;

    for (int i = 0; i < 32; i++) rom[i] = 32'hA500_0000 | (32'(i) << 8) | 32'(i);

    // inputs: rv, rpc, rdy | expected: rom_en, rom_addr, inst_valid, inst_pc
    vecs[0]  = '{1'b0, 7'd0,  1'b0, 1'b1, 7'd0,  1'b0, 7'd0};
    vecs[1]  = '{1'b0, 7'd0,  1'b0, 1'b1, 7'd4,  1'b1, 7'd0};
    vecs[2]  = '{1'b0, 7'd0,  1'b0, 1'b0, 7'd8,  1'b1, 7'd0};
    vecs[3]  = '{1'b0, 7'd0,  1'b0, 1'b0, 7'd8,  1'b1, 7'd0};
    vecs[4]  = '{1'b0, 7'd0,  1'b0, 1'b0, 7'd8,  1'b1, 7'd0};
    vecs[5]  = '{1'b0, 7'd0,  1'b0, 1'b0, 7'd8,  1'b1, 7'd0};
    vecs[6]  = '{1'b0, 7'd0,  1'b1, 1'b1, 7'd8,  1'b1, 7'd0};
    vecs[7]  = '{1'b0, 7'd0,  1'b1, 1'b1, 7'd12, 1'b1, 7'd4};
    vecs[8]  = '{1'b0, 7'd0,  1'b0, 1'b0, 7'd16, 1'b1, 7'd8};
    vecs[9]  = '{1'b1, 7'd12, 1'b0, 1'b0, 7'd16, 1'b1, 7'd8};
    vecs[10] = '{1'b0, 7'd0,  1'b0, 1'b1, 7'd12, 1'b0, 7'd0};
    vecs[11] = '{1'b0, 7'd0,  1'b1, 1'b1, 7'd16, 1'b1, 7'd12};
    vecs[12] = '{1'b1, 7'd13, 1'b1, 1'b0, 7'd20, 1'b1, 7'd16};
    vecs[13] = '{1'b0, 7'd0,  1'b1, 1'b1, 7'd12, 1'b0, 7'd0};
    vecs[14] = '{1'b0, 7'd0,  1'b1, 1'b1, 7'd16, 1'b1, 7'd12};

    rst_n = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 7'd0;
    bus_if.inst_ready     = 1'b0;
    tick();
    tick();

    // Reset state
    drive(1'b0, 1'b0, 7'd0, 1'b0);
    check("reset.inst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
    check("reset.inst_data", bus_if.inst_data, 32'd0);
    check("reset.inst_pc", {25'd0, bus_if.inst_pc}, 32'd0);
    check("reset.rom_en", {31'd0, bus_if.rom_en}, 32'd0);
    check("reset.rom_addr", {25'd0, bus_if.rom_addr}, 32'd0);
    tick();

    // Directed table: backpressure, release, redirects to 12 and 13
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      check($sformatf("vec%0d.rom_en", i), {31'd0, bus_if.rom_en}, {31'd0, vecs[i].en});
      check($sformatf("vec%0d.rom_addr", i), {25'd0, bus_if.rom_addr}, {25'd0, vecs[i].addr});
      check($sformatf("vec%0d.inst_valid", i), {31'd0, bus_if.inst_valid}, {31'd0, vecs[i].vld});
      if (vecs[i].vld) begin
        check($sformatf("vec%0d.inst_pc", i), {25'd0, bus_if.inst_pc}, {25'd0, vecs[i].ipc});
        check($sformatf("vec%0d.inst_data", i), bus_if.inst_data, rom[vecs[i].ipc[6:2]]);
      end
      tick();
    end

    // Streaming from reset with ready held high
    drive(1'b0, 1'b0, 7'd0, 1'b1);
    tick();
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b0, 7'd0, 1'b1);
      check("stream.rom_addr", {25'd0, bus_if.rom_addr}, 32'(4 * k));
      check("stream.inst_valid", {31'd0, bus_if.inst_valid}, (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        check("stream.inst_pc", {25'd0, bus_if.inst_pc}, 32'(4 * (k - 1)));
        check("stream.inst_data", bus_if.inst_data, rom[k - 1]);
      end
      tick();
    end

    // PC wrap-around from 120
    drive(1'b1, 1'b1, 7'd120, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 7'd0, 1'b1);
      check("wrap.rom_en", {31'd0, bus_if.rom_en}, 32'd1);
      check("wrap.rom_addr", {25'd0, bus_if.rom_addr}, (120 + 4 * k) % 128);
      if (k > 0) check("wrap.inst_pc", {25'd0, bus_if.inst_pc}, (120 + 4 * (k - 1)) % 128);
      tick();
    end

    // ecall at address 8
    rom[2] = 32'h0000_0073;
    drive(1'b0, 1'b0, 7'd0, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 7'd0, 1'b1);
`ifdef FETCH_HALT_EN
      exp_en   = (k <= 2);
      exp_addr = (k <= 2) ? 4 * k : 12;
      exp_vld  = (k >= 1) && (k <= 3);
`else
      exp_en   = 1'b1;
      exp_addr = 4 * k;
      exp_vld  = (k >= 1);
`endif
      check("ecall.rom_en", {31'd0, bus_if.rom_en}, {31'd0, exp_en});
      check("ecall.rom_addr", {25'd0, bus_if.rom_addr}, exp_addr);
      check("ecall.inst_valid", {31'd0, bus_if.inst_valid}, {31'd0, exp_vld});
      if (exp_vld) check("ecall.inst_pc", {25'd0, bus_if.inst_pc}, 4 * (k - 1));
      tick();
    end
    drive(1'b1, 1'b1, 7'd0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 7'd0, 1'b1);
    check("ecall.resume_en", {31'd0, bus_if.rom_en}, 32'd1);
    check("ecall.resume_addr", {25'd0, bus_if.rom_addr}, 32'd0);
    tick();
    rom[2] = 32'hA500_0202;

    // Reset while the queue is full and a fetch is in flight
    drive(1'b0, 1'b0, 7'd0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 7'd0, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 7'd0, 1'b1);
    check("midrst.rom_en_low", {31'd0, bus_if.rom_en}, 32'd0);
    check("midrst.full_before", {31'd0, bus_if.inst_valid}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 7'd0, 1'b1);
    check("midrst.inst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
    check("midrst.pc", {25'd0, bus_if.rom_addr}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 7'd0, 1'b1);
    check("midrst.rel_valid", {31'd0, bus_if.inst_valid}, 32'd0);
    check("midrst.rel_en", {31'd0, bus_if.rom_en}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 7'd0, 1'b1);
    exp_pc = 0;
    check("midrst.first_pc", {25'd0, bus_if.inst_pc}, exp_pc);
    check("midrst.first_data", bus_if.inst_data, rom[0]);
    tick();

    // Randomized run against the reference model
    for (int i = 0; i < 32; i++) begin
      rom[i] = ($urandom_range(0, 7) == 0) ? 32'h0000_0073 : $urandom;
    end
    drive(1'b0, 1'b0, 7'd0, 1'b0);
    tick();
    mq.delete();
    mpc   = 0;
    mhalt = 1'b0;
    for (int i = 0; i < 600; i++) begin
      model_cycle($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 127)), $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that drives the 7-bit byte-addressed, 32-bit-wide instruction ROM. It keeps the program counter, issues one ROM read per cycle, buffers fetched words with their PC in a 2-entry queue, and presents them to decode over a valid/ready handshake. Branch/jump redirects from execute flush the queue and restart fetch at the target.

## Interface
Parameters:
- ADDR_W, 7, ROM byte-address width; PC width.
- INST_W, 32, instruction width.
- RESET_PC, 7'd0, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rom_en  out  1  ROM read enable; high only in cycles that fetch.
- rom_addr  out  ADDR_W  ROM byte address, always word-aligned (bits [1:0] = 0).
- rom_data  in  INST_W  ROM read data; valid combinationally in the same cycle as rom_addr/rom_en.
- redirect_valid  in  1  load new PC this cycle.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored, treated as 0.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  INST_W  instruction at queue head.
- inst_pc  out  ADDR_W  byte address of inst_data.

## Operation
- Registers: pc (ADDR_W), 2-entry queue of {data, pc}, state.
- States: RUN (fetching), HALT (stopped; exists only with FETCH_HALT_EN).
- fetch = (state == RUN) && !redirect_valid && (queue not full || pop this cycle), where pop = inst_valid && inst_ready.
- rom_en = fetch; rom_addr = pc, always driven.
- On fetch: push {rom_data, pc}; pc <= pc + 4, wrapping modulo 2^ADDR_W (124 -> 0).
- On redirect_valid: the queue is cleared, pc <= {redirect_pc[ADDR_W-1:2], 2'b00}, state <= RUN, and nothing is pushed. A pop in the same cycle still counts as a completed handshake; the popped word is discarded downstream by the decoder's own redirect handling.
- Simultaneous push and pop on a full queue is allowed; occupancy is unchanged.
- Queue is FIFO; inst_data/inst_pc are the head entry, registered outputs.
- No stall input: backpressure comes only from inst_ready via queue full.

## Timing
- Reset (rst_n low at a rising edge): pc = RESET_PC, queue empty, state = RUN, inst_valid = 0, inst_data = 0, inst_pc = 0. rom_en = 0 while rst_n is low.
- First cycle with rst_n high: rom_en = 1, rom_addr = RESET_PC; inst_valid = 1 in the next cycle.
- Fetch-to-valid latency is 1 cycle. Redirect-to-valid latency is 2 cycles: the redirect cycle, then the target fetch, then valid.
- Throughput is 1 instruction per cycle while inst_ready is held high.
- With inst_ready low, fetch stops after 2 pushes; rom_en = 0 until a pop.
- Asserting rst_n low mid-operation drops all queued entries at that edge.

## Configuration
- FETCH_HALT_EN defined:
  - A fetched word equal to 32'h00000073 (ecall) is pushed normally, then state <= HALT.
  - In HALT, rom_en = 0 and pc holds. Queued words still drain.
  - Only redirect_valid or reset returns the block to RUN.
- FETCH_HALT_EN undefined: the HALT state and the compare logic are absent; ecall is fetched like any other word.

## Structure
- Shared package fetch_pkg holds ADDR_W, INST_W, the ECALL_WORD constant, the fetch state enum {RUN, HALT}, and the queue entry struct {data, pc}.
- One sub-module, fetch_queue: 2-entry synchronous FIFO with push, pop, flush, full, empty and head outputs. fetch_unit instantiates it and owns pc and the state machine.

## Test plan
- Reset then inst_ready = 1, ROM holding the 8-word program: inst_pc sequence 0,4,8,…,28 on consecutive cycles, inst_data matches the ROM words, first inst_valid on cycle 2 after reset release.
- Hold inst_ready = 0 for 5 cycles: exactly 2 fetches (addresses 0 and 4), then rom_en = 0. On release, words pop in order with no loss and no duplication.
- Redirect to 7'd12 while the queue holds 2 entries: queue flushes, next inst_valid delivers pc = 12. Redirect to 7'd13 also yields pc = 12.
- Run from pc = 120: fetch order 120, 124, 0, 4 (wrap-around).
- FETCH_HALT_EN with 32'h00000073 at address 8: words 0,4,8 delivered, rom_en stays 0 afterwards. A redirect to 0 resumes fetch. Without the macro, fetch continues to 12.
- Pull rst_n low while the queue is full and a fetch is in flight: at the next edge inst_valid = 0 and pc = RESET_PC, and no stale word appears after reset release.
